// File: rtl/led_feedback_if.sv
// Event/status bundle between the game FSM (master) and one LED feedback
// channel (slave).
interface led_feedback_if;
  logic       hit;
  logic       miss;
  logic [3:0] blink_n;
  logic       led;
  logic       busy;
  logic       done;

  modport master (output hit, miss, blink_n, input  led, busy, done);
  modport slave  (input  hit, miss, blink_n, output led, busy, done);
endinterface

// File: rtl/led_feedback.sv
// Turns one-cycle hit/miss event pulses into visible LED activity:
// a steady hold after a hit, a counted blink train after a miss.
module led_feedback #(
  parameter int unsigned HOLD_CYCLES = 25000000,
  parameter int unsigned BLINK_HALF  = 6250000,
  parameter int unsigned CNT_W       = 25
) (
  input logic           clk,
  input logic           rst,
  led_feedback_if.slave bus
);

  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_HALF - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HOLD      = 2'd1,
    BLINK_ON  = 2'd2,
    BLINK_OFF = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       blinks_left;
  logic             led_q;
  logic             busy_q;
  logic             done_q;

  logic valid_miss;
  assign valid_miss = bus.miss && (bus.blink_n != 4'd0);

  // A valid miss outranks everything, including a terminal count, so a
  // restart or preempt never produces a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      blinks_left <= 4'd0;
      led_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (valid_miss) begin
        state       <= BLINK_ON;
        cnt         <= '0;
        blinks_left <= bus.blink_n;
        led_q       <= 1'b1;
        busy_q      <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (bus.hit) begin
              state  <= HOLD;
              cnt    <= '0;
              led_q  <= 1'b1;
              busy_q <= 1'b1;
            end
          end
          HOLD: begin
            if (bus.hit) begin
              cnt <= '0;
            end else if (cnt == HOLD_LAST) begin
              state  <= IDLE;
              cnt    <= '0;
              led_q  <= 1'b0;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          BLINK_ON: begin
            if (cnt == BLINK_LAST) begin
              state <= BLINK_OFF;
              cnt   <= '0;
              led_q <= 1'b0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          BLINK_OFF: begin
            if (cnt == BLINK_LAST) begin
              cnt         <= '0;
              blinks_left <= blinks_left - 4'd1;
              if (blinks_left == 4'd1) begin
                state  <= IDLE;
                busy_q <= 1'b0;
                done_q <= 1'b1;
              end else begin
                state <= BLINK_ON;
                led_q <= 1'b1;
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: begin
            state  <= IDLE;
            cnt    <= '0;
            led_q  <= 1'b0;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.led  = led_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: doc/led_feedback.md
Name: led_feedback

Overview:
- Output-side counterpart of the button conditioning stage. Button conditioning turns a raw level into a one-cycle pulse; this block turns one-cycle game event pulses back into human-visible LED activity.
- A hit produces a steady LED hold. A miss produces a counted blink sequence.
- Sits between the game FSM and the board LED pins. One instance per mole/LED.

Parameters:
- HOLD_CYCLES, 25000000, number of cycles the LED stays on after a hit (0.5 s at 50 MHz); must be >= 1.
- BLINK_HALF, 6250000, cycles per on-phase and per off-phase of one blink; must be >= 1.
- CNT_W, 25, width of the phase counter; must satisfy 2^CNT_W > max(HOLD_CYCLES, BLINK_HALF).

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous reset, active-high.
- hit  input  1  one-cycle pulse from the game FSM: mole hit.
- miss  input  1  one-cycle pulse from the game FSM: mole missed / timed out.
- blink_n  input  4  number of blinks for a miss, sampled only on the cycle miss=1.
- led  output  1  LED drive, active high, registered.
- busy  output  1  high whenever not IDLE, registered.
- done  output  1  one-cycle pulse on the cycle the block returns to IDLE from HOLD or BLINK_OFF, registered.

Behaviour:
- Reset: a clock edge with rst=1 forces state=IDLE, led=0, busy=0, done=0, counter=0, blinks_left=0. Reset overrides hit and miss on the same edge, and aborts any sequence mid-operation.
- States: IDLE, HOLD, BLINK_ON, BLINK_OFF.
- Registered outputs:
  - led=1 exactly in HOLD and BLINK_ON.
  - busy=1 in every state except IDLE.
  - done is set for exactly one cycle per completed sequence.
- Latency: an event sampled at edge k makes led/busy change on the output after edge k; there is no extra cycle.

State transitions:
- IDLE:
  - miss=1 with blink_n!=0 -> BLINK_ON; latch blinks_left=blink_n; counter=0.
  - Otherwise hit=1 -> HOLD; counter=0.
  - miss=1 with blink_n=0 is ignored; a hit in the same cycle still goes to HOLD.
- HOLD:
  - Counter increments each cycle. On the cycle counter=HOLD_CYCLES-1 -> IDLE with done=1.
  - hit=1 restarts the hold (counter=0, stay in HOLD).
  - miss=1 with blink_n!=0 preempts: -> BLINK_ON with the new latch. No done pulse on preemption.
- BLINK_ON:
  - At counter=BLINK_HALF-1 -> BLINK_OFF; counter=0.
- BLINK_OFF:
  - At counter=BLINK_HALF-1: decrement blinks_left.
  - If the result is 0 -> IDLE with done=1; else -> BLINK_ON; counter=0.
- Any blink state:
  - miss=1 with blink_n!=0 restarts the sequence: -> BLINK_ON, blinks_left=blink_n, counter=0.
  - hit=1 is ignored.

Priority and boundary rules:
- Priority on simultaneous hit and miss: a valid miss (blink_n!=0) wins over hit.
- A restart or preempt on the same cycle as a terminal count takes priority over completion, so done=0.
- Exact durations:
  - Hit from IDLE: led high for exactly HOLD_CYCLES cycles.
  - Miss with blink_n=N: N on-phases and N off-phases, each exactly BLINK_HALF cycles, so busy is high for 2*N*BLINK_HALF cycles.
- blink_n=15 is the maximum; no wrap.
- Counters never exceed their terminal value.
- Inputs are assumed to be already single-cycle pulses from the button/FSM domain. A hit held high for several cycles in HOLD retriggers every cycle, which is legal.

Test Plan (HOLD_CYCLES=4, BLINK_HALF=2):
- Reset then idle 10 cycles -> led=0, busy=0, done=0 throughout.
- hit pulse at cycle 0 -> led=1 cycles 1-4, led=0 at cycle 5; done=1 only at cycle 5; busy mirrors led.
- miss with blink_n=3 at cycle 0 -> led pattern 1,1,0,0 repeated 3 times over cycles 1-12; busy=1 for 12 cycles; done=1 at cycle 13.
- hit at cycle 0, hit again at cycle 3 -> led stays high through cycle 7, falls at cycle 8; a single done at cycle 8.
- hit and miss (blink_n=1) on the same cycle from IDLE -> blink sequence 1,1,0,0. Then miss with blink_n=0 from IDLE -> no activity, busy=0.
- rst asserted during BLINK_ON of a blink_n=5 sequence -> led=0, busy=0 on the next cycle; done never pulses. A subsequent hit behaves as from power-up.
